// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding,
// default operand width and the full-subtractor truth function.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } serial_state_e;

    localparam int DEFAULT_WIDTH = 4;

    // Returns {borrow_out, difference} for x - y - bin.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
        logic d;
        logic bo;
        d  = x ^ y ^ bin;
        bo = (~x & y) | (~(x ^ y) & bin);
        return {bo, d};
    endfunction

endpackage

// File: rtl/full_subtractor_1bit.sv
// Single-bit combinational full subtractor: d = x - y - bin, with borrow out.
module full_subtractor_1bit
    import serial_arith_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic [1:0] res;

    // Truth function lives in the package so serial adder/divider blocks can share it.
    assign res  = full_sub(x, y, bin);
    assign d    = res[0];
    assign bout = res[1];

endmodule

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock, through
// a single full-subtractor cell and a registered borrow.
// Optional macro SERIAL_SUB_OVERFLOW_EN adds the signed-overflow output ov.
// WIDTH must be at least 2.
//
//   state | meaning
//   IDLE  | waiting for start; diff/bout hold the last result
//   SHIFT | one operand bit pair processed per cycle, busy high
//   DONE  | final bit done; publish diff/bout, pulse done, back to IDLE
module serial_subtractor_nbit
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
   ,output logic             ov
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    serial_state_e    state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ov_q, ov_d;
`endif

    logic fs_d;
    logic fs_bout;

    full_subtractor_1bit u_fs (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // Next-state and datapath: capture on start, shift per bit, publish at DONE.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ov_d    = ov_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            SHIFT: begin
                res_d  = {fs_d, res_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = fs_bout;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                diff_d  = res_q;
                bout_d  = br_q;
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef SERIAL_SUB_OVERFLOW_EN
                ov_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ res_q[WIDTH-1]);
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SHIFT);
    end

    // All state and registered outputs; synchronous reset aborts any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ov_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ov_q    <= ov_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign ov   = ov_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Directed bench for serial_subtractor_nbit (WIDTH=4). Define
// SERIAL_SUB_OVERFLOW_EN for both bench and RTL to cover the ov output.
module tb_serial_subtractor_nbit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [3:0] diff;
    logic       bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic       ov;
`endif

    int nerr = 0;
    int nchk = 0;

    serial_subtractor_nbit #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVERFLOW_EN
       ,.ov    (ov)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge with the DUT idle. Start is accepted at the next edge
    // (edge 0); values are sampled at the negedge before each later edge k.
    task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                          input logic [3:0] ediff, input logic ebout);
        int         done_at;
        int         busy_cnt;
        logic       held;
        logic [3:0] prev;
        prev  = diff;
        held  = 1'b1;
        a     = ta;
        b     = tb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = ~ta;
        b     = ~tb;
        done_at  = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_at = k;
                break;
            end
            if (diff !== prev) held = 1'b0;
        end
        chk({tag, "_latency"}, done_at, 6);
        chk({tag, "_busy_cycles"}, busy_cnt, 4);
        chk({tag, "_diff_held"}, {31'd0, held}, 1);
        chk({tag, "_diff"}, {28'd0, diff}, {28'd0, ediff});
        chk({tag, "_bout"}, {31'd0, bout}, {31'd0, ebout});
`ifdef SERIAL_SUB_OVERFLOW_EN
        begin
            int sa;
            int sb;
            int r;
            sa = ta[3] ? int'(ta) - 16 : int'(ta);
            sb = tb[3] ? int'(tb) - 16 : int'(tb);
            r  = sa - sb;
            chk({tag, "_ov"}, {31'd0, ov}, ((r > 7) || (r < -8)) ? 32'd1 : 32'd0);
        end
`endif
        @(negedge clk);
        chk({tag, "_done_width"}, {31'd0, done}, 0);
    endtask

    initial begin
        int ndone;
        int last_done;
        int gap_bad;

        reset = 1'b1;
        start = 1'b0;
        a     = 4'd0;
        b     = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_diff", {28'd0, diff}, 0);
        chk("rst_bout", {31'd0, bout}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 0);

        run_op("v6m3", 4'b0110, 4'b0011, 4'b0011, 1'b0);
        run_op("v3m6", 4'b0011, 4'b0110, 4'b1101, 1'b1);
        run_op("v0m1", 4'b0000, 4'b0001, 4'b1111, 1'b1);
        run_op("v15m1", 4'b1111, 4'b0001, 4'b1110, 1'b0);
        run_op("v0m0", 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Start held high: results every 6 cycles, start during SHIFT/DONE ignored.
        a     = 4'b1001;
        b     = 4'b0110;
        start = 1'b1;
        ndone     = 0;
        last_done = 0;
        gap_bad   = 0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                chk("hold_diff", {28'd0, diff}, 32'd3);
                chk("hold_bout", {31'd0, bout}, 0);
                if (last_done != 0 && (k - last_done) != 6) gap_bad++;
                last_done = k;
            end
        end
        start = 1'b0;
        chk("hold_ndone", ndone, 3);
        chk("hold_gap", gap_bad, 0);
        chk("hold_last", last_done, 18);
        @(negedge clk);
        @(negedge clk);

        // Reset during the second SHIFT cycle aborts without a done pulse.
        a     = 4'b0110;
        b     = 4'b0011;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_done", {31'd0, done}, 0);
        chk("abort_diff", {28'd0, diff}, 0);
        chk("abort_bout", {31'd0, bout}, 0);
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run_op("after_abort", 4'b0110, 4'b0011, 4'b0011, 1'b0);

`ifdef SERIAL_SUB_OVERFLOW_EN
        run_op("ov_7m15", 4'b0111, 4'b1111, 4'b1000, 1'b1);
        chk("ov_7m15_direct", {31'd0, ov}, 1);
        run_op("ov_8m1", 4'b1000, 4'b0001, 4'b0111, 1'b0);
        chk("ov_8m1_direct", {31'd0, ov}, 1);
        run_op("ov_5m3", 4'b0101, 4'b0011, 4'b0010, 1'b0);
        chk("ov_5m3_direct", {31'd0, ov}, 0);
`endif

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                logic [3:0] ea;
                logic [3:0] eb;
                logic [3:0] ed;
                ea = 4'(i);
                eb = 4'(j);
                ed = 4'((i - j) & 15);
                run_op($sformatf("sweep_%0d_%0d", i, j), ea, eb, ed, (i < j));
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_nbit.md
Name: serial_subtractor_nbit

Overview:
Bit-serial subtractor computing diff = a - b, one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
It is the inverse-operation counterpart of the parallel ripple-carry adder: same operand and result shape, with borrow-out in place of carry-out.
It serves as a low-area arithmetic unit behind a start/busy/done handshake and as a sequential building block for later iterative divider work.

Parameters:
WIDTH, 4, operand and result width in bits (must be >= 2)

Ports:
clk    input   1      system clock; all state updates on rising edge
reset  input   1      synchronous reset, active-high
start  input   1      request; sampled only in IDLE
a      input   WIDTH  minuend; captured on the accepted start cycle
b      input   WIDTH  subtrahend; captured on the accepted start cycle
busy   output  1      high while an operation is in progress (SHIFT state)
done   output  1      one-cycle pulse when diff and bout become valid
diff   output  WIDTH  a - b modulo 2^WIDTH; held until the next accepted start
bout   output  1      final borrow; 1 exactly when a < b (unsigned)

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, done=0, diff=0, bout=0; shift registers, borrow and counter cleared. Reset mid-operation aborts with no done pulse.
- FSM states:
  - IDLE: start=1 -> latch a, b into shift registers; borrow=0; count=0; go to SHIFT. start=0 -> stay.
  - SHIFT: busy=1. Each cycle:
    - d = a0 ^ b0 ^ br
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
    - shift d into diff result register at the MSB, shifting right
    - shift the a and b registers right; count++
    - after the WIDTH-th bit, go to DONE.
  - DONE: done=1 for exactly this cycle; bout=final borrow; unconditionally return to IDLE.
- Latency: start accepted at edge 0 -> busy high for edges 1..WIDTH -> done high for the cycle after edge WIDTH+1. Total WIDTH+2 cycles start-to-done. Back-to-back throughput: one result per WIDTH+2 cycles.
- start while busy or in DONE: ignored, no queuing. a and b changes after capture have no effect.
- diff and bout are registered and change only at the done edge; they stay stable in IDLE. During SHIFT they hold the previous result.
- Widths: counter is clog2(WIDTH+1) bits; no internal width beyond WIDTH+1.
- Wrap: 0 - 1 yields all-ones with bout=1.

Optional Feature:
Macro SERIAL_SUB_OVERFLOW_EN.
- Defined: adds output port ov (1 bit), registered with diff. ov = (a_msb ^ b_msb) & (a_msb ^ diff_msb), i.e. two's-complement signed overflow of a - b, using the captured operand MSBs. Reset value 0; updates only at done.
- Not defined: port and logic absent; unsigned behaviour unchanged.

Decomposition:
- Shared package serial_arith_pkg:
  - state encoding localparams IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
  - default width constant
  - full-subtractor truth function, reused later by serial adder/divider blocks
- One sub-module: full_subtractor_1bit (combinational; inputs x, y, bin; outputs d, bout), instantiated once in the datapath.

Test Plan:
- WIDTH=4, a=0110, b=0011, start pulse -> done exactly 6 cycles after start; diff=0011, bout=0; busy high for 4 cycles.
- a=0011, b=0110 -> diff=1101, bout=1. a=0000, b=0001 -> diff=1111, bout=1. a=1111, b=0001 -> diff=1110, bout=0. a=0000, b=0000 -> diff=0000, bout=0.
- Hold start=1 continuously with a=1001, b=0110 -> results diff=0011, bout=0, one done per 6 cycles; start during busy/DONE ignored, and changing a/b mid-op does not alter the result.
- Assert reset at second SHIFT cycle -> next cycle busy=0, done=0, diff=0, bout=0; no done pulse; next start computes correctly.
- Exhaustive sweep of all 256 a/b pairs (WIDTH=4) -> diff == (a-b) mod 16 and bout == (a<b) for each.
- With SERIAL_SUB_OVERFLOW_EN:
  - a=0111, b=1111 -> diff=1000, ov=1
  - a=1000, b=0001 -> diff=0111, ov=1
  - a=0101, b=0011 -> diff=0010, ov=0
